alu: RTL and testbench

- 4-bit registered ALU: add, subtract, magnitude compare and bitwise AND, chosen by a 2-bit select.
- Leaf datapath block; all results and flags are registered and update one cycle after the operands are sampled.
- Downstream logic reads only the result group for the selected operation; the other groups read zero.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_core.sv | 80 ++++++++
 rtl/alu.sv | 88 ++++++++
 tb/tb_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the registered 4-bit ALU.
// Imported by alu_core and alu.
package alu_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_AND = 2'b11
    } op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; only the selected result group is non-zero.
// Optional zero flag Z is built when ALU_ZERO_FLAG_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] add_result,
    output logic             bit5,
    output logic [WIDTH-1:0] sub_result,
    output logic             sub_sign,
    output logic [WIDTH-1:0] and_result,
    output logic             GT,
    output logic             EQ,
    output logic             LT
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             Z
`endif
);

    op_t            op;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign op = op_t'(S);

    // Both arithmetic results are one bit wider to keep carry and sign.
    always_comb begin
        sum  = {1'b0, A} + {1'b0, B};
        diff = {1'b0, A} - {1'b0, B};
    end

    // Drive the selected group; every other group is held at zero.
    always_comb begin
        add_result = '0;
        bit5       = 1'b0;
        sub_result = '0;
        sub_sign   = 1'b0;
        and_result = '0;
        GT         = 1'b0;
        EQ         = 1'b0;
        LT         = 1'b0;
`ifdef ALU_ZERO_FLAG_EN
        Z          = 1'b0;
`endif
        unique case (op)
            OP_ADD: begin
                {bit5, add_result} = sum;
`ifdef ALU_ZERO_FLAG_EN
                Z = (sum == '0);
`endif
            end
            OP_SUB: begin
                {sub_sign, sub_result} = diff;
`ifdef ALU_ZERO_FLAG_EN
                Z = (diff == '0);
`endif
            end
            OP_CMP: begin
                GT = (A > B);
                EQ = (A == B);
                LT = (A < B);
`ifdef ALU_ZERO_FLAG_EN
                Z = (A == B);
`endif
            end
            OP_AND: begin
                and_result = A & B;
`ifdef ALU_ZERO_FLAG_EN
                Z = ((A & B) == '0);
`endif
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency, async active-high reset.
// Define ALU_ZERO_FLAG_EN to add the registered zero flag output Z.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] add_result,
    output logic             bit5,
    output logic [WIDTH-1:0] sub_result,
    output logic             sub_sign,
    output logic [WIDTH-1:0] and_result,
    output logic             GT,
    output logic             EQ,
    output logic             LT
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             Z
`endif
);

    logic [WIDTH-1:0] c_add;
    logic             c_bit5;
    logic [WIDTH-1:0] c_sub;
    logic             c_sign;
    logic [WIDTH-1:0] c_and;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
`ifdef ALU_ZERO_FLAG_EN
    logic             c_z;
`endif

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .S         (S),
        .A         (A),
        .B         (B),
        .add_result(c_add),
        .bit5      (c_bit5),
        .sub_result(c_sub),
        .sub_sign  (c_sign),
        .and_result(c_and),
        .GT        (c_gt),
        .EQ        (c_eq),
        .LT        (c_lt)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .Z         (c_z)
`endif
    );

    // Capture all result groups each edge; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_result <= '0;
            bit5       <= 1'b0;
            sub_result <= '0;
            sub_sign   <= 1'b0;
            and_result <= '0;
            GT         <= 1'b0;
            EQ         <= 1'b0;
            LT         <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            Z          <= 1'b0;
`endif
        end else begin
            add_result <= c_add;
            bit5       <= c_bit5;
            sub_result <= c_sub;
            sub_sign   <= c_sign;
            and_result <= c_and;
            GT         <= c_gt;
            EQ         <= c_eq;
            LT         <= c_lt;
`ifdef ALU_ZERO_FLAG_EN
            Z          <= c_z;
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors with hand-computed results.
// Expected values are queued at issue and checked one edge later.
module tb_alu;

    typedef struct packed {
        logic [3:0] add;
        logic       c;
        logic [3:0] sub;
        logic       sg;
        logic [3:0] an;
        logic       gt;
        logic       eq;
        logic       lt;
        logic       z;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] S   = 2'b00;
    logic [3:0] A   = 4'd0;
    logic [3:0] B   = 4'd0;
    logic [3:0] add_result;
    logic       bit5;
    logic [3:0] sub_result;
    logic       sub_sign;
    logic [3:0] and_result;
    logic       GT;
    logic       EQ;
    logic       LT;
`ifdef ALU_ZERO_FLAG_EN
    logic       Z;
`endif

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];

    alu #(
        .WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .A         (A),
        .B         (B),
        .add_result(add_result),
        .bit5      (bit5),
        .sub_result(sub_result),
        .sub_sign  (sub_sign),
        .and_result(and_result),
        .GT        (GT),
        .EQ        (EQ),
        .LT        (LT)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .Z         (Z)
`endif
    );

    always #5 clk = ~clk;

    function automatic res_t actual();
        res_t r;
        r.add = add_result;
        r.c   = bit5;
        r.sub = sub_result;
        r.sg  = sub_sign;
        r.an  = and_result;
        r.gt  = GT;
        r.eq  = EQ;
        r.lt  = LT;
`ifdef ALU_ZERO_FLAG_EN
        r.z   = Z;
`else
        r.z   = 1'b0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input res_t exp);
        res_t got;
        got = actual();
`ifndef ALU_ZERO_FLAG_EN
        exp.z = 1'b0;
`endif
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b_%b_%b_%b_%b_%b%b%b_%b exp=%b_%b_%b_%b_%b_%b%b%b_%b",
                     name,
                     got.c, got.add, got.sg, got.sub, got.an,
                     got.gt, got.eq, got.lt, got.z,
                     exp.c, exp.add, exp.sg, exp.sub, exp.an,
                     exp.gt, exp.eq, exp.lt, exp.z);
        end
    endtask

    // Monitor: every edge the DUT presents a result; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check("pipe", exp_q.pop_front());
        end
    end

    // Issue one operation at the falling edge and queue its expectation.
    task automatic issue(
        input logic [3:0] a, input logic [3:0] b,
        input logic [1:0] s,
        input logic c, input logic [3:0] add,
        input logic sg, input logic [3:0] sub,
        input logic [3:0] an,
        input logic gt, input logic eq, input logic lt,
        input logic z);
        res_t e;
        @(negedge clk);
        A = a;
        B = b;
        S = s;
        e = '{add: add, c: c, sub: sub, sg: sg, an: an,
              gt: gt, eq: eq, lt: lt, z: z};
        exp_q.push_back(e);
    endtask

    initial begin
        res_t zero;
        res_t full;
        zero = '0;
        full = '0;
        full.add = 4'b1110;
        full.c   = 1'b1;

        #2;
        check("reset_init", zero);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", zero);
        @(negedge clk);
        rst = 1'b0;

        //     A      B      S      c     add      sg    sub      and      g  e  l  z
        issue(4'd4,  4'd10, 2'b00, 1'b0, 4'b1110, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        issue(4'd2,  4'd13, 2'b00, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        issue(4'd15, 4'd15, 2'b00, 1'b1, 4'b1110, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        issue(4'd0,  4'd0,  2'b00, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        issue(4'd15, 4'd13, 2'b01, 1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        issue(4'd13, 4'd10, 2'b01, 1'b0, 4'b0000, 1'b0, 4'b0011, 4'b0000, 0, 0, 0, 0);
        issue(4'd2,  4'd13, 2'b01, 1'b0, 4'b0000, 1'b1, 4'b0101, 4'b0000, 0, 0, 0, 0);
        issue(4'd10, 4'd5,  2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        issue(4'd15, 4'd15, 2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 1, 0, 1);
        issue(4'd7,  4'd1,  2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        issue(4'd1,  4'd7,  2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        issue(4'd15, 4'd12, 2'b11, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1100, 0, 0, 0, 0);
        issue(4'd10, 4'd5,  2'b11, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        // Back-to-back switching through every select value.
        issue(4'd3,  4'd3,  2'b00, 1'b0, 4'b0110, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        issue(4'd3,  4'd3,  2'b01, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        issue(4'd3,  4'd3,  2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 1, 0, 1);
        issue(4'd3,  4'd3,  2'b11, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0011, 0, 0, 0, 0);
        issue(4'd9,  4'd6,  2'b00, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        issue(4'd9,  4'd6,  2'b10, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        issue(4'd6,  4'd9,  2'b01, 1'b0, 4'b0000, 1'b1, 4'b1101, 4'b0000, 0, 0, 0, 0);
        issue(4'd9,  4'd6,  2'b11, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 1);

        // Mid-stream reset with 15+15 in flight.
        issue(4'd15, 4'd15, 2'b00, 1'b1, 4'b1110, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", zero);
        @(posedge clk);
        #1;
        check("reset_edge", zero);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(full);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
